press_classifier: RTL

Consumes the debounced, single-bit level from the noise-suppression stage (1 = pressed) and classifies each gesture as a short press, long press or double press. Time is measured in prescaled ticks. Each classified event is delivered on a one-entry valid/ready output buffer. A sticky flag reports events dropped under backpressure. The block sits directly downstream of the noise suppressor and feeds the control/register logic.

---
 rtl/press_pkg.sv | 21 ++
 rtl/tick_prescaler.sv | 28 ++
 rtl/press_classifier.sv | 122 ++++++++++++
 3 files changed

// File: rtl/press_pkg.sv
// Shared types for the press classifier: event codes and FSM states.
package press_pkg;

    localparam int unsigned EVT_W = 2;

    typedef enum logic [EVT_W-1:0] {
        EVT_NONE   = 2'b00,
        EVT_SHORT  = 2'b01,
        EVT_LONG   = 2'b10,
        EVT_DOUBLE = 2'b11
    } evt_code_t;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        WAIT_REL
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider; tick is a registered one-cycle pulse every TICK_DIV clocks.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= wrap;
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced presses as short/long/double and delivers them on a
// one-entry valid/ready buffer with a sticky drop flag.
module press_classifier
    import press_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned LONG_TICKS = 500,
    parameter int unsigned GAP_TICKS  = 150,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             d_clean,
    output logic             evt_valid,
    output logic [EVT_W-1:0] evt_code,
    input  logic             evt_ready,
    output logic             overflow,
    input  logic             clear_ovf
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

    logic             d_prev;
    logic             rise;
    logic             fall;
    logic             tick;
    logic [CNT_W-1:0] cnt;
    state_t           state;
    state_t           next_state;
    logic             emit;
    evt_code_t        emit_code;
    logic             consume;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // d_prev resets high so a level already asserted at reset release is not a press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) d_prev <= 1'b1;
        else          d_prev <= d_clean;
    end

    assign rise = d_clean & ~d_prev;
    assign fall = ~d_clean & d_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Edges take priority over a tick expiry in the same cycle
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (rise) next_state = PRESS1;
            PRESS1: begin
                if (fall)                           next_state = GAP;
                else if (tick && cnt == LONG_LAST)  next_state = WAIT_REL;
            end
            GAP: begin
                if (rise)                           next_state = PRESS2;
                else if (tick && cnt == GAP_LAST)   next_state = IDLE;
            end
            PRESS2:   if (fall) next_state = IDLE;
            WAIT_REL: if (fall) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        emit      = 1'b0;
        emit_code = EVT_NONE;
        unique case (state)
            PRESS1: if (!fall && tick && cnt == LONG_LAST) begin
                emit      = 1'b1;
                emit_code = EVT_LONG;
            end
            GAP: if (!rise && tick && cnt == GAP_LAST) begin
                emit      = 1'b1;
                emit_code = EVT_SHORT;
            end
            PRESS2: if (fall) begin
                emit      = 1'b1;
                emit_code = EVT_DOUBLE;
            end
            default: ;
        endcase
    end

    // Saturating tick counter, restarted on every state change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  cnt <= '0;
        else if (next_state != state)  cnt <= '0;
        else if (tick && cnt != '1)    cnt <= cnt + 1'b1;
    end

    assign consume = evt_valid & evt_ready;

    // A same-cycle consume frees the slot for a new event; otherwise a full slot drops it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid <= 1'b0;
            evt_code  <= EVT_NONE;
            overflow  <= 1'b0;
        end else begin
            if (emit && (!evt_valid || consume)) begin
                evt_valid <= 1'b1;
                evt_code  <= emit_code;
            end else if (consume) begin
                evt_valid <= 1'b0;
                evt_code  <= EVT_NONE;
            end
            if (emit && evt_valid && !consume) overflow <= 1'b1;
            else if (clear_ovf)                overflow <= 1'b0;
        end
    end

endmodule
